match_rate_monitor: RTL and testbench

//  Downstream consumer of the 11-01-10 Mealy recognizer output Z. Samples Z every Ck,

---
 rtl/match_rate_monitor.sv | 92 +++++++++
 tb/tb_match_rate_monitor.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/match_rate_monitor.sv
// Match-rate monitor: saturating total count, sliding-window count and
// a three-state rate FSM with hysteresis on the recognizer's Z output.
module match_rate_monitor #(
    parameter int CNT_W  = 8,
    parameter int WIN    = 16,
    parameter int THRESH = 3
) (
    input  logic                     Ck,
    input  logic                     reset,
    input  logic                     Z,
    input  logic                     clr,
    output logic [CNT_W-1:0]         count,
    output logic                     ovf,
    output logic [$clog2(WIN+1)-1:0] wcount,
    output logic                     active,
    output logic                     alarm
);

    localparam int WW = $clog2(WIN+1);
    localparam logic [CNT_W-1:0] CMAX = '1;
    localparam logic [WW-1:0]    THR  = WW'(THRESH);

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        ACTIVE = 2'b01,
        ALARM  = 2'b10,
        BAD    = 2'b11
    } state_t;

    state_t         state;
    state_t         nxt;
    logic [WIN-1:0] hist;
    logic [WW-1:0]  wn;

    // The window count can never exceed WIN, so WW bits never wrap.
    always_comb begin
        wn = wcount + WW'(Z) - WW'(hist[WIN-1]);
    end

    always_comb begin
        nxt = IDLE;
        case (state)
            IDLE: begin
                if (wn >= THR)
                    nxt = ALARM;
                else if (wn != '0)
                    nxt = ACTIVE;
                else
                    nxt = IDLE;
            end
            ACTIVE: begin
                if (wn >= THR)
                    nxt = ALARM;
                else if (wn == '0)
                    nxt = IDLE;
                else
                    nxt = ACTIVE;
            end
            ALARM: begin
                if (wn == '0)
                    nxt = IDLE;
                else
                    nxt = ALARM;
            end
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge Ck) begin
        if (reset || clr) begin
            count  <= '0;
            ovf    <= 1'b0;
            hist   <= '0;
            wcount <= '0;
            state  <= IDLE;
        end else begin
            hist   <= {hist[WIN-2:0], Z};
            wcount <= wn;
            state  <= nxt;
            if (Z) begin
                if (count == CMAX)
                    ovf <= 1'b1;
                else
                    count <= count + 1'b1;
            end
        end
    end

    assign active = (state != IDLE);
    assign alarm  = (state == ALARM);

endmodule

// File: tb/tb_match_rate_monitor.sv
// Directed bench for match_rate_monitor: default instance plus a
// 2-bit counter instance for saturation and overflow.
module tb_match_rate_monitor;

    logic       Ck = 1'b0;
    logic       reset = 1'b1;
    logic       Z = 1'b0;
    logic       clr = 1'b0;
    logic [7:0] count;
    logic       ovf;
    logic [4:0] wcount;
    logic       active;
    logic       alarm;

    logic       sat_z = 1'b0;
    logic       sat_clr = 1'b0;
    logic [1:0] sat_count;
    logic       sat_ovf;
    logic [4:0] sat_wcount;
    logic       sat_active;
    logic       sat_alarm;

    int checks = 0;
    int errors = 0;

    match_rate_monitor u_dut (
        .Ck(Ck), .reset(reset), .Z(Z), .clr(clr),
        .count(count), .ovf(ovf), .wcount(wcount),
        .active(active), .alarm(alarm)
    );

    match_rate_monitor #(.CNT_W(2)) u_sat (
        .Ck(Ck), .reset(reset), .Z(sat_z), .clr(sat_clr),
        .count(sat_count), .ovf(sat_ovf), .wcount(sat_wcount),
        .active(sat_active), .alarm(sat_alarm)
    );

    always #5 Ck = ~Ck;

    always @(posedge Ck) begin
        if (!reset)
            assert (!$isunknown(Z) && !$isunknown(sat_z))
            else $error("FAIL z_known: Z is unknown after reset");
    end

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge Ck);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        Z = 1'b0;
        clr = 1'b0;
        sat_z = 1'b0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    function automatic int exp_w2(int c);
        if (c >= 24) return 0;
        if (c >= 21) return 1;
        if (c >= 18) return 2;
        if (c >= 8)  return 3;
        if (c >= 5)  return 2;
        if (c >= 2)  return 1;
        return 0;
    endfunction

    function automatic int exp_c2(int c);
        if (c >= 8) return 3;
        if (c >= 5) return 2;
        if (c >= 2) return 1;
        return 0;
    endfunction

    initial begin
        // reset state
        do_reset();
        chk("rst_count", count, 0);
        chk("rst_ovf", ovf, 0);
        chk("rst_wcount", wcount, 0);
        chk("rst_active", active, 0);
        chk("rst_alarm", alarm, 0);

        // pulses at 2,5,8 then drain of the window
        do_reset();
        for (int c = 1; c <= 26; c++) begin
            Z = (c == 2 || c == 5 || c == 8);
            tick();
            chk($sformatf("win_wcount_c%0d", c), wcount, exp_w2(c));
            chk($sformatf("win_count_c%0d", c), count, exp_c2(c));
            chk($sformatf("win_alarm_c%0d", c), alarm,
                (c >= 8 && c < 24) ? 1 : 0);
            chk($sformatf("win_active_c%0d", c), active,
                (c >= 2 && c < 24) ? 1 : 0);
        end
        Z = 1'b0;

        // sparse pulses: never alarm, toggles IDLE/ACTIVE
        do_reset();
        for (int c = 1; c <= 100; c++) begin
            Z = ((c - 1) % 20 == 0);
            tick();
            chk($sformatf("sp_wcount_c%0d", c), wcount,
                ((c - 1) % 20 < 16) ? 1 : 0);
            chk($sformatf("sp_active_c%0d", c), active,
                ((c - 1) % 20 < 16) ? 1 : 0);
            chk($sformatf("sp_alarm_c%0d", c), alarm, 0);
        end
        Z = 1'b0;
        chk("sp_count", count, 5);

        // saturation on the 2-bit instance
        do_reset();
        for (int i = 1; i <= 5; i++) begin
            sat_z = 1'b1;
            tick();
            chk($sformatf("sat_count_p%0d", i), sat_count, (i > 3) ? 3 : i);
            chk($sformatf("sat_ovf_p%0d", i), sat_ovf, (i >= 4) ? 1 : 0);
        end
        sat_z = 1'b0;
        tick();
        chk("sat_ovf_sticky", sat_ovf, 1);

        // clear while in ALARM, Z in the clear cycle discarded
        do_reset();
        for (int i = 0; i < 3; i++) begin
            Z = 1'b1;
            tick();
        end
        chk("pre_clr_alarm", alarm, 1);
        chk("pre_clr_wcount", wcount, 3);
        Z = 1'b1;
        clr = 1'b1;
        tick();
        clr = 1'b0;
        Z = 1'b0;
        chk("clr_count", count, 0);
        chk("clr_wcount", wcount, 0);
        chk("clr_active", active, 0);
        chk("clr_alarm", alarm, 0);
        for (int i = 0; i < 20; i++) begin
            tick();
            chk($sformatf("post_clr_w%0d", i), wcount, 0);
        end

        // reset while ACTIVE
        Z = 1'b1;
        tick();
        Z = 1'b0;
        chk("pre_rst_active", active, 1);
        chk("pre_rst_count", count, 1);
        reset = 1'b1;
        Z = 1'b1;
        tick();
        reset = 1'b0;
        Z = 1'b0;
        chk("mid_rst_count", count, 0);
        chk("mid_rst_ovf", ovf, 0);
        chk("mid_rst_wcount", wcount, 0);
        chk("mid_rst_active", active, 0);
        chk("mid_rst_alarm", alarm, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
